// File: rtl/rr_drain_arbiter_if.sv
// Stream bundle between the arbiter, the upstream linked-list FIFO and the downstream sink.
// The slave modport is the arbiter's view; the master modport is the FIFO/sink side.
interface rr_drain_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int QID_WIDTH = $clog2(NUM_FIFOS)
);
  logic                 en;
  logic [NUM_FIFOS-1:0] empty;
  logic [WIDTH-1:0]     fifo_data;
  logic [NUM_FIFOS-1:0] pop;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [QID_WIDTH-1:0] out_qid;

  modport master (
    output en, empty, fifo_data, out_ready,
    input  pop, out_valid, out_data, out_qid
  );

  modport slave (
    input  en, empty, fifo_data, out_ready,
    output pop, out_valid, out_data, out_qid
  );
endinterface

// File: rtl/rr_drain_arbiter.sv
// Round-robin drain of a multi-queue FIFO: one pop per cycle, the word returns a cycle
// later and lands in a 2-entry skid buffer that feeds a qid-tagged valid/ready stream.
module rr_drain_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int QID_WIDTH = $clog2(NUM_FIFOS)
) (
  input logic              clk,
  input logic              rst,
  rr_drain_arbiter_if.slave bus
);

  typedef logic [QID_WIDTH-1:0] qid_t;
  typedef struct packed {
    qid_t             qid;
    logic [WIDTH-1:0] data;
  } entry_t;

  qid_t       last_grant_q, last_grant_d;
  logic       inflight_q, inflight_d;
  qid_t       inflight_qid_q, inflight_qid_d;
  entry_t     slot_q [2];
  entry_t     slot_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;

  logic       deq;
  logic [2:0] occupancy;
  logic       room;
  logic       found_hi, found_lo;
  qid_t       sel_hi, sel_lo, sel;
  logic       grant;
  logic [NUM_FIFOS-1:0] pop_vec;

  // Round-robin pick: first non-empty queue above the last grant, else the first one at or
  // below it. Iterating only over 0..NUM_FIFOS-1 keeps odd queue counts in range.
  // NOTE: always_comb uses blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (!bus.empty[i]) begin
        if (i > int'(last_grant_q)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            sel_hi   = QID_WIDTH'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          sel_lo   = QID_WIDTH'(i);
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  // A word may be issued only if it is guaranteed a buffer slot when it returns.
  always_comb begin
    deq       = (cnt_q != 2'd0) & bus.out_ready;
    occupancy = {1'b0, cnt_q} + {2'b00, inflight_q};
    room      = occupancy < (3'd2 + {2'b00, deq});
    grant     = !rst && bus.en && !(&bus.empty) && room && (found_hi || found_lo);
    pop_vec   = '0;
    if (grant) pop_vec[sel] = 1'b1;
  end

  always_comb begin
    last_grant_d   = last_grant_q;
    inflight_d     = grant;
    inflight_qid_d = inflight_qid_q;
    slot_d         = slot_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;

    if (grant) begin
      last_grant_d   = sel;
      inflight_qid_d = sel;
    end

    if (inflight_q) begin
      slot_d[wr_ptr_q] = '{qid: inflight_qid_q, data: bus.fifo_data};
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (deq) rd_ptr_d = ~rd_ptr_q;

    unique case ({inflight_q, deq})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: the two buffer slots are reset as well, because the head slot drives out_data
  // directly and must read 0 out of reset; a deeper memory would be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q   <= QID_WIDTH'(NUM_FIFOS - 1);
      inflight_q     <= 1'b0;
      inflight_qid_q <= '0;
      slot_q[0]      <= '0;
      slot_q[1]      <= '0;
      cnt_q          <= 2'd0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
    end else begin
      last_grant_q   <= last_grant_d;
      inflight_q     <= inflight_d;
      inflight_qid_q <= inflight_qid_d;
      slot_q         <= slot_d;
      cnt_q          <= cnt_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
    end
  end

  assign bus.pop       = pop_vec;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = slot_q[rd_ptr_q].data;
  assign bus.out_qid   = slot_q[rd_ptr_q].qid;

  // Returning words must always find a free slot.
  no_capture_into_full : assert property (
    @(posedge clk) disable iff (rst) !(cnt_q == 2'd2 && inflight_q && !deq)
  );

endmodule

// File: tb/tb_rr_drain_arbiter.sv
// Bench for rr_drain_arbiter: directed vector table, a 3-queue wrap sequence, and a
// randomized run against a pop-order scoreboard model.
module tb_rr_drain_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_drain_arbiter_if #(.WIDTH(8), .NUM_FIFOS(2), .QID_WIDTH(1)) bus2 ();
  rr_drain_arbiter_if #(.WIDTH(8), .NUM_FIFOS(3), .QID_WIDTH(2)) bus3 ();

  rr_drain_arbiter #(.WIDTH(8), .NUM_FIFOS(2), .QID_WIDTH(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );
  rr_drain_arbiter #(.WIDTH(8), .NUM_FIFOS(3), .QID_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int checks   = 0;
  int failures = 0;

  // Upstream FIFO contents for the 2-queue DUT.
  logic [7:0] fq [2][$];

  // Scoreboard: every issued pop, in order, with the cycle it becomes visible.
  typedef struct {
    int         qid;
    logic [7:0] data;
    int         ready_cyc;
  } sb_t;
  sb_t sb[$];
  int  last_g;
  int  cyc;

  typedef struct {
    int         seg;
    bit         en;
    bit         rdy;
    logic [1:0] pop;
    bit         valid;
    int         qid;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int seg, input bit en, input bit rdy, input logic [1:0] pop,
                     input bit valid, input int qid, input logic [7:0] data);
    vec_t v;
    v = '{seg: seg, en: en, rdy: rdy, pop: pop, valid: valid, qid: qid, data: data};
    tbl.push_back(v);
  endtask

  task automatic update_empty();
    for (int i = 0; i < 2; i++) bus2.empty[i] = (fq[i].size() == 0);
  endtask

  // Take one clock edge; the FIFO returns the popped word one cycle after the pop.
  task automatic advance();
    logic [1:0] p;
    bit         done;
    p    = bus2.pop;
    done = 1'b0;
    @(posedge clk);
    #1;
    bus2.fifo_data = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (!done && p[i] && fq[i].size() > 0) begin
        bus2.fifo_data = fq[i].pop_front();
        done = 1'b1;
      end
    end
    update_empty();
    @(negedge clk);
  endtask

  task automatic model_reset();
    sb.delete();
    last_g = 1;
    cyc    = 0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus2.en        = 1'b1;
    bus2.out_ready = 1'b1;
    update_empty();
    #1;
    check("pop forced low in reset", 32'(bus2.pop), 32'd0);
    advance();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_seg(input int s);
    fq[0].delete();
    fq[1].delete();
    case (s)
      1: begin fq[0] = '{8'hA5, 8'h3C}; end
      2: begin fq[0] = '{8'h11, 8'h12}; fq[1] = '{8'h21, 8'h22}; end
      3: begin fq[0] = '{8'h31, 8'h32, 8'h33}; fq[1] = '{8'h41, 8'h42, 8'h43}; end
      4: begin fq[0] = '{8'h51, 8'h52, 8'h53}; end
      5: begin fq[0] = '{8'h61, 8'h62}; end
      6: begin fq[0] = '{8'h81}; fq[1] = '{8'h91}; end
      default: ;
    endcase
  endtask

  // Reference: grant whenever enabled, something is queued and the pop can be
  // buffered; the grant goes to the next non-empty queue after the previous one.
  task automatic model_step();
    bit exp_valid;
    bit deq_e;
    bit grant;
    int j;
    int jj;
    exp_valid = (sb.size() > 0) && (sb[0].ready_cyc <= cyc);
    check("rand out_valid", 32'(bus2.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("rand out_data", 32'(bus2.out_data), 32'(sb[0].data));
      check("rand out_qid", 32'(bus2.out_qid), 32'(sb[0].qid));
    end
    deq_e = exp_valid && bus2.out_ready;
    grant = 1'b0;
    j     = 0;
    if (bus2.en && sb.size() < 2 + int'(deq_e)) begin
      for (int k = 1; k <= 2; k++) begin
        jj = (last_g + k) % 2;
        if (!grant && fq[jj].size() > 0) begin
          grant = 1'b1;
          j     = jj;
        end
      end
    end
    check("rand pop", 32'(bus2.pop), grant ? (32'd1 << j) : 32'd0);
    if (deq_e) void'(sb.pop_front());
    if (grant) begin
      sb_t e;
      e = '{qid: j, data: fq[j][0], ready_cyc: cyc + 2};
      sb.push_back(e);
      last_g = j;
    end
    cyc++;
  endtask

  initial begin
    int cur;
    rst            = 1'b1;
    bus2.en        = 1'b0;
    bus2.empty     = '1;
    bus2.fifo_data = '0;
    bus2.out_ready = 1'b0;
    bus3.en        = 1'b0;
    bus3.empty     = '1;
    bus3.fifo_data = '0;
    bus3.out_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset values.
    load_seg(0);
    do_reset();
    #1;
    check("reset out_valid", 32'(bus2.out_valid), 32'd0);
    check("reset out_data", 32'(bus2.out_data), 32'd0);
    check("reset out_qid", 32'(bus2.out_qid), 32'd0);

    // seg, en, rdy, pop, valid, qid, data
    add(1, 1, 1, 2'b01, 0, 0, 8'h00); add(1, 1, 1, 2'b01, 0, 0, 8'h00);
    add(1, 1, 1, 2'b00, 1, 0, 8'hA5); add(1, 1, 1, 2'b00, 1, 0, 8'h3C);
    add(1, 1, 1, 2'b00, 0, 0, 8'h00);
    add(2, 1, 1, 2'b01, 0, 0, 8'h00); add(2, 1, 1, 2'b10, 0, 0, 8'h00);
    add(2, 1, 1, 2'b01, 1, 0, 8'h11); add(2, 1, 1, 2'b10, 1, 1, 8'h21);
    add(2, 1, 1, 2'b00, 1, 0, 8'h12); add(2, 1, 1, 2'b00, 1, 1, 8'h22);
    add(2, 1, 1, 2'b00, 0, 0, 8'h00);
    add(3, 1, 0, 2'b01, 0, 0, 8'h00); add(3, 1, 0, 2'b10, 0, 0, 8'h00);
    add(3, 1, 0, 2'b00, 1, 0, 8'h31); add(3, 1, 0, 2'b00, 1, 0, 8'h31);
    add(3, 1, 0, 2'b00, 1, 0, 8'h31); add(3, 1, 1, 2'b01, 1, 0, 8'h31);
    add(3, 1, 1, 2'b10, 1, 1, 8'h41); add(3, 1, 1, 2'b01, 1, 0, 8'h32);
    add(3, 1, 1, 2'b10, 1, 1, 8'h42); add(3, 1, 1, 2'b00, 1, 0, 8'h33);
    add(3, 1, 1, 2'b00, 1, 1, 8'h43); add(3, 1, 1, 2'b00, 0, 0, 8'h00);
    add(4, 1, 1, 2'b01, 0, 0, 8'h00); add(4, 0, 1, 2'b00, 0, 0, 8'h00);
    add(4, 0, 1, 2'b00, 1, 0, 8'h51); add(4, 0, 1, 2'b00, 0, 0, 8'h00);
    add(4, 1, 1, 2'b01, 0, 0, 8'h00); add(4, 0, 1, 2'b00, 0, 0, 8'h00);
    add(4, 0, 1, 2'b00, 1, 0, 8'h52); add(4, 0, 1, 2'b00, 0, 0, 8'h00);
    add(5, 1, 0, 2'b01, 0, 0, 8'h00); add(5, 1, 0, 2'b01, 0, 0, 8'h00);
    add(6, 1, 1, 2'b01, 0, 0, 8'h00); add(6, 1, 1, 2'b10, 0, 0, 8'h00);
    add(6, 1, 1, 2'b00, 1, 0, 8'h81); add(6, 1, 1, 2'b00, 1, 1, 8'h91);
    add(6, 1, 1, 2'b00, 0, 0, 8'h00);

    cur = -1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].seg != cur) begin
        cur = tbl[i].seg;
        load_seg(cur);
        do_reset();
      end
      bus2.en        = tbl[i].en;
      bus2.out_ready = tbl[i].rdy;
      #1;
      check($sformatf("seg%0d row%0d pop", cur, i), 32'(bus2.pop), 32'(tbl[i].pop));
      check($sformatf("seg%0d row%0d out_valid", cur, i), 32'(bus2.out_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        check($sformatf("seg%0d row%0d out_data", cur, i), 32'(bus2.out_data), 32'(tbl[i].data));
        check($sformatf("seg%0d row%0d out_qid", cur, i), 32'(bus2.out_qid), 32'(tbl[i].qid));
      end
      advance();
    end

    // Three queues: last grant starts at 2, so the scan wraps through 0 and 1.
    bus2.en        = 1'b0;
    bus3.en        = 1'b1;
    bus3.out_ready = 1'b1;
    bus3.empty     = 3'b011;
    rst            = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("n3 wrap grant q2", 32'(bus3.pop), 32'b100);
    check("n3 idle valid", 32'(bus3.out_valid), 32'd0);
    @(posedge clk); #1;
    bus3.fifo_data = 8'hC7;
    bus3.empty     = 3'b010;
    #1;
    check("n3 wrap to q0", 32'(bus3.pop), 32'b001);
    check("n3 latency valid", 32'(bus3.out_valid), 32'd0);
    @(posedge clk); #1;
    bus3.fifo_data = 8'hD0;
    bus3.empty     = 3'b011;
    #1;
    check("n3 skip q1 grant q2", 32'(bus3.pop), 32'b100);
    check("n3 valid 1", 32'(bus3.out_valid), 32'd1);
    check("n3 qid 1", 32'(bus3.out_qid), 32'd2);
    check("n3 data 1", 32'(bus3.out_data), 32'hC7);
    @(posedge clk); #1;
    bus3.fifo_data = 8'hC8;
    bus3.empty     = 3'b111;
    #1;
    check("n3 no pop when all empty", 32'(bus3.pop), 32'd0);
    check("n3 qid 2", 32'(bus3.out_qid), 32'd0);
    check("n3 data 2", 32'(bus3.out_data), 32'hD0);
    @(posedge clk); #2;
    check("n3 qid 3", 32'(bus3.out_qid), 32'd2);
    check("n3 data 3", 32'(bus3.out_data), 32'hC8);
    @(posedge clk); #2;
    check("n3 drained", 32'(bus3.out_valid), 32'd0);
    bus3.en = 1'b0;
    @(negedge clk);

    // Randomized run against the scoreboard model.
    load_seg(0);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int q = 0; q < 2; q++) begin
        if ($urandom_range(0, 2) == 0 && fq[q].size() < 6) fq[q].push_back(8'($urandom));
      end
      update_empty();
      bus2.en        = ($urandom_range(0, 9) != 0);
      bus2.out_ready = ((c / 300) % 2 == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      model_step();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
